// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Multiply and divide results are computed from operands latched at the
// Start edge and written to HI/LO when the busy down-counter reaches zero.
// The divider is built only when the MDU_DIV_EN macro is defined; without it
// div/divu are treated exactly like the reserved opcodes.
//
// state | meaning
// IDLE  | accepts Start; mthi/mtlo write HI/LO directly
// MUL   | multiply in flight, Busy high, counting down MULT_CYCLES
// DIV   | divide in flight, Busy high, counting down DIV_CYCLES
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    // The counter is loaded with cycles-1, so it never has to hold MAX_CYCLES.
    localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
`ifdef MDU_DIV_EN
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
`endif

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
`ifdef MDU_DIV_EN
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
`endif
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic             op_unsigned;

    // Signed and unsigned products share one 64x64 multiplier: sign-extending
    // (or zero-extending) both operands to 64 bits gives the right low 64 bits.
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] prod;

    // Operand extension and product for the multiply path
    always_comb begin
        ext_a = {{32{a_q[31] & ~op_unsigned}}, a_q};
        ext_b = {{32{b_q[31] & ~op_unsigned}}, b_q};
        prod  = ext_a * ext_b;
    end

`ifdef MDU_DIV_EN
    // Signed divide is done on magnitudes with the signs fixed up afterwards,
    // which also yields 0x80000000 / -1 = 0x80000000 rem 0 without overflow.
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        div_zero;

    // Quotient/remainder from the latched operands
    always_comb begin
        neg_a    = a_q[31] & ~op_unsigned;
        neg_b    = b_q[31] & ~op_unsigned;
        mag_a    = neg_a ? (~a_q + 32'd1) : a_q;
        mag_b    = neg_b ? (~b_q + 32'd1) : b_q;
        div_zero = (b_q == 32'd0);
        // Keep the divide well defined on B=0; the result is discarded anyway.
        divisor  = div_zero ? 32'd1 : mag_b;
        quo_mag  = mag_a / divisor;
        rem_mag  = mag_a % divisor;
        quo      = (neg_a ^ neg_b) ? (~quo_mag + 32'd1) : quo_mag;
        rem      = neg_a ? (~rem_mag + 32'd1) : rem_mag;
    end
`endif

    // Control FSM, busy down-counter and HI/LO registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            Busy        <= 1'b0;
            HI          <= 32'd0;
            LO          <= 32'd0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            op_unsigned <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        case (MDOp)
                            OP_MULT, OP_MULTU: begin
                                a_q         <= A;
                                b_q         <= B;
                                op_unsigned <= MDOp[0];
                                cnt         <= MULT_LOAD;
                                Busy        <= 1'b1;
                                state       <= ST_MUL;
                            end
`ifdef MDU_DIV_EN
                            OP_DIV, OP_DIVU: begin
                                a_q         <= A;
                                b_q         <= B;
                                op_unsigned <= MDOp[0];
                                cnt         <= DIV_LOAD;
                                Busy        <= 1'b1;
                                state       <= ST_DIV;
                            end
`endif
                            OP_MTHI: HI <= A;
                            OP_MTLO: LO <= A;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (cnt == '0) begin
                        HI    <= prod[63:32];
                        LO    <= prod[31:0];
                        Busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DIV: begin
`ifdef MDU_DIV_EN
                    if (cnt == '0) begin
                        if (!div_zero) begin
                            HI <= rem;
                            LO <= quo;
                        end
                        Busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
`else
                    Busy  <= 1'b0;
                    state <= ST_IDLE;
`endif
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with an expected-result queue.
// Follows the MDU_DIV_EN macro of the build to predict div/divu behaviour.
module tb_mult_div_unit;

    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] sb[$];

    mult_div_unit #(.MULT_CYCLES(MULT_CYC), .DIV_CYCLES(DIV_CYC)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp),
        .A(A), .B(B), .Busy(Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: updates m_hi/m_lo, returns expected Busy cycle count.
    function automatic int model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa;
        int              sbv;
        int              cyc;
        cyc = 0;
        sa  = a;
        sbv = b;
        case (op)
            3'b000: begin
                sp = longint'(sa) * longint'(sbv);
                {m_hi, m_lo} = 64'(sp);
                cyc = MULT_CYC;
            end
            3'b001: begin
                up = longint'({32'd0, a}) * longint'({32'd0, b});
                {m_hi, m_lo} = 64'(up);
                cyc = MULT_CYC;
            end
`ifdef MDU_DIV_EN
            3'b010: begin
                cyc = DIV_CYC;
                if (b != 32'd0) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        m_lo = 32'h8000_0000;
                        m_hi = 32'd0;
                    end else begin
                        m_lo = 32'(sa / sbv);
                        m_hi = 32'(sa % sbv);
                    end
                end
            end
            3'b011: begin
                cyc = DIV_CYC;
                if (b != 32'd0) begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
`endif
            3'b100: m_hi = a;
            3'b101: m_lo = a;
            default: ;
        endcase
        return cyc;
    endfunction

    task automatic wait_busy(output int n);
        n = 0;
        while (Busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int exp_cyc;
        int n;
        exp_cyc = model(op, a, b);
        sb.push_back({m_hi, m_lo});
        @(negedge clk);
        Start = 1'b1; MDOp = op; A = a; B = b;
        check({tag, "_busy_in_start"}, 64'(Busy), 64'd0);
        @(negedge clk);
        Start = 1'b0; A = $urandom; B = $urandom; MDOp = 3'($urandom);
        wait_busy(n);
        check({tag, "_cycles"}, 64'(n), 64'(exp_cyc));
        check({tag, "_hilo"}, {HI, LO}, sb.pop_front());
    endtask

    initial begin
        int n;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1; Start = 1'b0; MDOp = 3'd0; A = 32'd0; B = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        #2;
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_hilo", {HI, LO}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("mult",  3'b000, 32'hFFFF_FFFE, 32'd3);
        check("mult_const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("multu", 3'b001, 32'hFFFF_FFFE, 32'd3);
        check("multu_const", {HI, LO}, 64'h0000_0002_FFFF_FFFA);
        run_op("mthi", 3'b100, 32'h0000_1234, 32'd0);
        run_op("mtlo", 3'b101, 32'h0000_5678, 32'd0);
        run_op("div_by_zero", 3'b010, 32'd99, 32'd0);
        check("div_by_zero_const", {HI, LO}, 64'h0000_1234_0000_5678);
        run_op("div_neg", 3'b010, 32'hFFFF_FFF9, 32'd2);
        run_op("divu", 3'b011, 32'd7, 32'd2);
        run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rsvd6", 3'b110, 32'hDEAD_BEEF, 32'd1);
        run_op("rsvd7", 3'b111, 32'hDEAD_BEEF, 32'd1);

        // Idle with Start low: nothing moves
        A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; MDOp = 3'b100;
        repeat (4) @(negedge clk);
        check("idle_hold", {HI, LO}, {m_hi, m_lo});
        check("idle_busy", 64'(Busy), 64'd0);

        // mtlo requested on the 2nd Busy cycle of a multiply must be ignored
        n = model(3'b000, 32'd1000, 32'd77);
        sb.push_back({m_hi, m_lo});
        @(negedge clk);
        Start = 1'b1; MDOp = 3'b000; A = 32'd1000; B = 32'd77;
        @(negedge clk);
        Start = 1'b0;
        @(negedge clk);
        Start = 1'b1; MDOp = 3'b101; A = 32'h0000_AAAA;
        @(negedge clk);
        Start = 1'b0;
        wait_busy(n);
        check("inject_cycles", 64'(n + 2), 64'(MULT_CYC));
        check("inject_hilo", {HI, LO}, sb.pop_front());

        for (int i = 0; i < 6; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 5000));
            if (rb == 32'd0) rb = 32'd1;
            run_op("rand", rop, ra, rb);
        end

        // Reset on the 3rd Busy cycle aborts the operation
        begin
            logic [2:0] abort_op;
`ifdef MDU_DIV_EN
            abort_op = 3'b010;
`else
            abort_op = 3'b000;
`endif
            n = model(abort_op, 32'd500, 32'd7);
            m_hi = 32'd0; m_lo = 32'd0;
            @(negedge clk);
            Start = 1'b1; MDOp = abort_op; A = 32'd500; B = 32'd7;
            @(negedge clk);
            Start = 1'b0;
            @(negedge clk);
            @(negedge clk);
            reset = 1'b1;
            #1;
            check("abort_busy", 64'(Busy), 64'd0);
            check("abort_hilo", {HI, LO}, 64'd0);
            @(negedge clk);
            reset = 1'b0;
        end
        run_op("mult_after_reset", 3'b000, 32'd2, 32'd3);
        check("mult_after_reset_const", {HI, LO}, 64'd6);

        // Without the divider, div must look like a reserved op
`ifndef MDU_DIV_EN
        run_op("div_disabled", 3'b010, 32'd100, 32'd5);
        check("div_disabled_const", {HI, LO}, 64'd6);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter: MULT_CYCLES, default 5, number of Busy cycles for mult/multu.
REQ-002 Parameter: DIV_CYCLES, default 10, number of Busy cycles for div/divu.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: Start  input  1  E-stage op request, one-cycle qualifier for MDOp/A/B.
REQ-006 Port: MDOp  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 reserved.
REQ-007 Port: A  input  32  operand rs / mthi-mtlo data.
REQ-008 Port: B  input  32  operand rt.
REQ-009 Port: Busy  output  1  operation in progress; feeds the hazard unit with Start.
REQ-010 Port: HI  output  32  HI register (high product / remainder).
REQ-011 Port: LO  output  32  LO register (low product / quotient).

Function
REQ-012 States SHALL be IDLE, MUL, DIV; counter width sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-013 In IDLE, Start with MDOp mult/multu at edge T SHALL latch A, B and op, enter MUL, Busy=1 for exactly MULT_CYCLES cycles after T.
REQ-014 In IDLE, Start with MDOp div/divu SHALL likewise enter DIV with Busy=1 for exactly DIV_CYCLES cycles.
REQ-015 Busy SHALL NOT assert in the Start cycle itself, since the hazard unit covers it via Start.
REQ-016 HI/LO SHALL update at the edge ending the last Busy cycle: visible the same cycle Busy drops, then return to IDLE.
REQ-017 mult SHALL form a signed 64-bit product; multu an unsigned one; HI=[63:32], LO=[31:0].
REQ-018 div SHALL be signed, quotient truncated toward zero, remainder carries the dividend's sign; divu unsigned; LO=quotient, HI=remainder.
REQ-019 div 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-020 Divide by zero (B=0) SHALL still hold Busy for DIV_CYCLES and leave HI/LO unchanged.
REQ-021 mthi/mtlo with Start in IDLE SHALL write A into HI/LO at that edge, with no Busy.
REQ-022 Start while Busy=1 SHALL be ignored (no state, counter, or operand change).
REQ-023 Start with reserved MDOp SHALL be ignored; Start=0 SHALL cause no change.
REQ-024 HI/LO SHALL hold their values at all times except REQ-016/021 writes.
REQ-025 A/B changes after the Start edge SHALL NOT affect the result.

Reset
REQ-026 reset=1 SHALL immediately force IDLE, Busy=0, HI=0, LO=0, counter=0, independent of clk.
REQ-027 reset during MUL/DIV SHALL abort the operation and discard its result; the first Start after reset release SHALL behave as from IDLE.

Configuration
REQ-028 Macro MDU_DIV_EN defined: div/divu SHALL operate per REQ-014/018/019/020.
REQ-029 Macro MDU_DIV_EN undefined: no divider logic SHALL exist; div/divu SHALL behave as reserved ops per REQ-023 (no Busy, HI/LO unchanged).

Verification
REQ-030 mult A=0xFFFFFFFE, B=3 -> Busy high 5 cycles after Start; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-031 div A=0xFFFFFFF9 (-7), B=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 -> LO=3, HI=1.
REQ-032 div with B=0 after mthi 0x1234/mtlo 0x5678 -> Busy 10 cycles; HI=0x1234, LO=0x5678 unchanged.
REQ-033 mult started, then Start(mtlo 0xAAAA) on the 2nd Busy cycle -> ignored; final LO equals the product.
REQ-034 reset pulsed on the 3rd Busy cycle of div -> Busy=0, HI=LO=0 at once; a following mult 2x3 -> LO=6 after 5 cycles.
REQ-035 Build without MDU_DIV_EN: Start div -> Busy stays 0, HI/LO unchanged.
